e203_exu_alu_divseq: RTL

//  Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU) that acts as the muldiv-side initiator of the shared ALU datapath.
//  - Owns no adder: issues muldiv_req_alu_* requests and consumes the combinational result.
//  - Keeps its partial remainder and quotient in the datapath shared buffers (sbf_0 = remainder, sbf_1 = dividend/quotient).
//  - Sits between the EXU dispatch (cmd) and the longpipe writeback (rsp).

---
 rtl/e203_exu_alu_divseq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/e203_exu_alu_divseq.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) driving the shared ALU adder.
// Partial remainder lives in sbf_0, dividend/quotient in sbf_1.
module e203_exu_alu_divseq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_wdat,
  output logic        muldiv_req_alu,
  output logic [34:0] muldiv_req_alu_op1,
  output logic [34:0] muldiv_req_alu_op2,
  output logic        muldiv_req_alu_add,
  output logic        muldiv_req_alu_sub,
  input  logic [34:0] muldiv_req_alu_res,
  output logic        muldiv_sbf_0_ena,
  output logic [32:0] muldiv_sbf_0_nxt,
  input  logic [32:0] muldiv_sbf_0_r,
  output logic        muldiv_sbf_1_ena,
  output logic [32:0] muldiv_sbf_1_nxt,
  input  logic [32:0] muldiv_sbf_1_r
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SBF_W = XLEN + 1;
  localparam int unsigned ALU_W = XLEN + 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ABSA = 3'd1;
  localparam logic [2:0] ST_ABSB = 3'd2;
  localparam logic [2:0] ST_ITER = 3'd3;
  localparam logic [2:0] ST_FIXQ = 3'd4;
  localparam logic [2:0] ST_FIXR = 3'd5;
  localparam logic [2:0] ST_RSP  = 3'd6;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             op_rem;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  rs1_r, rs2_r;
  logic [SBF_W-1:0] dvsr_r;
  logic             accept, dvsr_ena;
  logic [SBF_W-1:0] sh;
  logic             q;
  logic             cmd_sgn;
  logic             unused_res_bit;

  assign sh             = {muldiv_sbf_0_r[XLEN-1:0], muldiv_sbf_1_r[XLEN-1]};
  assign q              = ~muldiv_req_alu_res[ALU_W-1];
  assign cmd_sgn        = ~cmd_op[0];
  assign unused_res_bit = muldiv_req_alu_res[ALU_W-2];
  assign rsp_wdat       = op_rem ? muldiv_sbf_0_r[XLEN-1:0] : muldiv_sbf_1_r[XLEN-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Operand capture and divisor magnitude
  always_ff @(posedge clk) begin
    if (rst) begin
      op_rem <= 1'b0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      rs1_r  <= '0;
      rs2_r  <= '0;
      dvsr_r <= '0;
    end else begin
      if (accept) begin
        op_rem <= cmd_op[1];
        a_neg  <= cmd_sgn & cmd_rs1[XLEN-1];
        b_neg  <= cmd_sgn & cmd_rs2[XLEN-1];
        rs1_r  <= cmd_rs1;
        rs2_r  <= cmd_rs2;
      end
      if (dvsr_ena) dvsr_r <= muldiv_req_alu_res[SBF_W-1:0];
    end
  end

  // Next state and datapath requests
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    accept             = 1'b0;
    dvsr_ena           = 1'b0;
    cmd_ready          = 1'b0;
    rsp_valid          = 1'b0;
    muldiv_req_alu     = 1'b0;
    muldiv_req_alu_op1 = '0;
    muldiv_req_alu_op2 = '0;
    muldiv_req_alu_add = 1'b0;
    muldiv_req_alu_sub = 1'b0;
    muldiv_sbf_0_ena   = 1'b0;
    muldiv_sbf_0_nxt   = '0;
    muldiv_sbf_1_ena   = 1'b0;
    muldiv_sbf_1_nxt   = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = ~flush;
        if (cmd_valid && !flush) begin
          accept = 1'b1;
          if (cmd_rs2 == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend
            muldiv_sbf_1_ena = 1'b1;
            muldiv_sbf_1_nxt = 33'h0_FFFF_FFFF;
            muldiv_sbf_0_ena = 1'b1;
            muldiv_sbf_0_nxt = {1'b0, cmd_rs1};
            state_nxt        = ST_RSP;
          end else begin
            state_nxt = ST_ABSA;
          end
        end
      end
      ST_ABSA: begin
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_op2 = {{3{a_neg}}, rs1_r};
        muldiv_req_alu_sub = a_neg;
        muldiv_req_alu_add = ~a_neg;
        muldiv_sbf_1_ena   = 1'b1;
        muldiv_sbf_1_nxt   = muldiv_req_alu_res[SBF_W-1:0];
        state_nxt          = ST_ABSB;
      end
      ST_ABSB: begin
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_op2 = {{3{b_neg}}, rs2_r};
        muldiv_req_alu_sub = b_neg;
        muldiv_req_alu_add = ~b_neg;
        dvsr_ena           = 1'b1;
        muldiv_sbf_0_ena   = 1'b1;
        state_nxt          = ST_ITER;
      end
      ST_ITER: begin
        // One restoring step: trial-subtract divisor from shifted remainder
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_op1 = {2'b00, sh};
        muldiv_req_alu_op2 = {2'b00, dvsr_r};
        muldiv_req_alu_sub = 1'b1;
        muldiv_sbf_0_ena   = 1'b1;
        muldiv_sbf_0_nxt   = q ? muldiv_req_alu_res[SBF_W-1:0] : sh;
        muldiv_sbf_1_ena   = 1'b1;
        muldiv_sbf_1_nxt   = {1'b0, muldiv_sbf_1_r[XLEN-2:0], q};
        cnt_nxt            = cnt + CNT_W'(1);
        if (cnt == CNT_W'(XLEN - 1)) state_nxt = ST_FIXQ;
      end
      ST_FIXQ: begin
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_op2 = {2'b00, muldiv_sbf_1_r};
        muldiv_req_alu_sub = a_neg ^ b_neg;
        muldiv_req_alu_add = ~(a_neg ^ b_neg);
        muldiv_sbf_1_ena   = 1'b1;
        muldiv_sbf_1_nxt   = muldiv_req_alu_res[SBF_W-1:0];
        state_nxt          = ST_FIXR;
      end
      ST_FIXR: begin
        muldiv_req_alu     = 1'b1;
        muldiv_req_alu_op2 = {2'b00, muldiv_sbf_0_r};
        muldiv_req_alu_sub = a_neg;
        muldiv_req_alu_add = ~a_neg;
        muldiv_sbf_0_ena   = 1'b1;
        muldiv_sbf_0_nxt   = muldiv_req_alu_res[SBF_W-1:0];
        state_nxt          = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

endmodule
